// File: rtl/zeroriscy_multdiv_arb.sv
// Two-port front end for the shared slow multiplier/divider.
// Port 0 is the core pipeline and port 1 is the coprocessor. The block grants
// one port at a time and holds that port's operands steady to the multdiv unit
// until the unit reports ready. The result goes into a per-port response
// register. A port-0 result is dropped if a flush killed its operation.
//
// Handshake semantics (both directions):
//   request : a transfer happens in a cycle where req_valid_i[p] and
//             req_ready_o[p] are both 1. req_ready_o is combinational and is
//             high for at most one port, and only in IDLE. A port is offered
//             a grant only while its response register is empty.
//   response: rsp_valid_o[p] stays high with a stable rsp_result_o[p] until
//             a cycle with rsp_ready_i[p]=1, then clears at the next edge.
//             kill_i also clears a pending port-0 response.
module zeroriscy_multdiv_arb #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][1:0]  req_operator_i,
    input  logic [1:0][1:0]  req_signed_mode_i,
    input  logic [1:0][31:0] req_op_a_i,
    input  logic [1:0][31:0] req_op_b_i,
    input  logic             kill_i,
    output logic [1:0]       rsp_valid_o,
    output logic [1:0][31:0] rsp_result_o,
    input  logic [1:0]       rsp_ready_i,
    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    input  logic             md_ready_i,
    input  logic [31:0]      md_result_i,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mult_en_q, mult_en_d;
    logic             div_en_q, div_en_d;
    logic             rr_ptr_q;
    logic             owner_q;
    logic             killed_q;
    logic [1:0]       op_q;
    logic [1:0]       mode_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_result_q;

    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic             gnt_port;
    logic             capture;
    logic             drop;

    // Eligibility and arbitration: at most one grant, only in IDLE
    always_comb begin
        eligible    = 2'b00;
        grant       = 2'b00;
        eligible[0] = req_valid_i[0] & ~rsp_valid_q[0] & ~kill_i;
        eligible[1] = req_valid_i[1] & ~rsp_valid_q[1];
        if (state_q == IDLE) begin
            if (&eligible) begin
                // Contention: fixed priority favours port 0, otherwise the pointer decides
                grant = (FIXED_PRIO || !rr_ptr_q) ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
        gnt_port = grant[1];
    end

    // FSM next state; enables are precomputed so they leave a flop
    always_comb begin
        state_d   = state_q;
        mult_en_d = mult_en_q;
        div_en_d  = div_en_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d   = BUSY;
                    mult_en_d = ~req_operator_i[gnt_port][1];
                    div_en_d  = req_operator_i[gnt_port][1];
                end
            end
            BUSY: begin
                if (md_ready_i) begin
                    state_d   = GAP;
                    mult_en_d = 1'b0;
                    div_en_d  = 1'b0;
                end
            end
            GAP: begin
                // One idle cycle so the unit settles before the next operation
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mult_en_d = 1'b0;
                div_en_d  = 1'b0;
            end
        endcase
    end

    // Response valid bits: capture wins, else consume or flush clears
    always_comb begin
        capture     = (state_q == BUSY) & md_ready_i;
        drop        = ~owner_q & (killed_q | kill_i);
        rsp_valid_d = rsp_valid_q;
        if (capture & ~owner_q & ~drop) begin
            rsp_valid_d[0] = 1'b1;
        end else if (rsp_ready_i[0] | kill_i) begin
            rsp_valid_d[0] = 1'b0;
        end
        if (capture & owner_q) begin
            rsp_valid_d[1] = 1'b1;
        end else if (rsp_ready_i[1]) begin
            rsp_valid_d[1] = 1'b0;
        end
    end

    // FSM state register together with the registered enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mult_en_q <= 1'b0;
            div_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mult_en_q <= mult_en_d;
            div_en_q  <= div_en_d;
        end
    end

    // Datapath: latch the winner's request, track kills, capture results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            killed_q     <= 1'b0;
            op_q         <= 2'b00;
            mode_q       <= 2'b00;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (|grant) begin
                owner_q  <= gnt_port;
                op_q     <= req_operator_i[gnt_port];
                mode_q   <= req_signed_mode_i[gnt_port];
                a_q      <= req_op_a_i[gnt_port];
                b_q      <= req_op_b_i[gnt_port];
                killed_q <= 1'b0;
                rr_ptr_q <= ~rr_ptr_q;
            end
            // The unit cannot abort, so a killed op runs on and its result is dropped
            if ((state_q == BUSY) && !owner_q && kill_i) begin
                killed_q <= 1'b1;
            end
            if (capture && !drop) begin
                rsp_result_q[owner_q] <= md_result_i;
            end
        end
    end

    assign req_ready_o      = grant;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = rsp_result_q;
    assign md_mult_en_o     = mult_en_q;
    assign md_div_en_o      = div_en_q;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = mode_q;
    assign md_op_a_o        = a_q;
    assign md_op_b_o        = b_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_zeroriscy_multdiv_arb.sv
// Bench for zeroriscy_multdiv_arb. Instance 0 runs round-robin and
// instance 1 runs fixed priority. A transaction-level reference keeps each
// instance's timeline in latency terms, and the bench also plays the multdiv
// unit, returning arithmetic results after the documented latencies.
module tb_zeroriscy_multdiv_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals (index 0 = rr, 1 = fixed prio) ----------------
  logic [1:0]       req_valid [2];
  logic [1:0]       req_ready [2];
  logic [1:0][1:0]  req_operator [2];
  logic [1:0][1:0]  req_mode [2];
  logic [1:0][31:0] req_a [2];
  logic [1:0][31:0] req_b [2];
  logic             kill [2];
  logic [1:0]       rsp_valid [2];
  logic [1:0][31:0] rsp_result [2];
  logic [1:0]       rsp_ready [2];
  logic             md_mult_en [2];
  logic             md_div_en [2];
  logic [1:0]       md_operator [2];
  logic [1:0]       md_mode [2];
  logic [31:0]      md_a [2];
  logic [31:0]      md_b [2];
  logic             md_ready [2];
  logic [31:0]      md_result [2];
  logic [1:0]       dbg_state [2];

  zeroriscy_multdiv_arb #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_operator_i(req_operator[0]), .req_signed_mode_i(req_mode[0]),
    .req_op_a_i(req_a[0]), .req_op_b_i(req_b[0]), .kill_i(kill[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_result_o(rsp_result[0]), .rsp_ready_i(rsp_ready[0]),
    .md_mult_en_o(md_mult_en[0]), .md_div_en_o(md_div_en[0]),
    .md_operator_o(md_operator[0]), .md_signed_mode_o(md_mode[0]),
    .md_op_a_o(md_a[0]), .md_op_b_o(md_b[0]),
    .md_ready_i(md_ready[0]), .md_result_i(md_result[0]), .dbg_state(dbg_state[0])
  );

  zeroriscy_multdiv_arb #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_operator_i(req_operator[1]), .req_signed_mode_i(req_mode[1]),
    .req_op_a_i(req_a[1]), .req_op_b_i(req_b[1]), .kill_i(kill[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_result_o(rsp_result[1]), .rsp_ready_i(rsp_ready[1]),
    .md_mult_en_o(md_mult_en[1]), .md_div_en_o(md_div_en[1]),
    .md_operator_o(md_operator[1]), .md_signed_mode_o(md_mode[1]),
    .md_op_a_o(md_a[1]), .md_op_b_o(md_b[1]),
    .md_ready_i(md_ready[1]), .md_result_i(md_result[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard / reference state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q0[$];   // results of granted, not yet finished ops (rr)
  logic [31:0] exp_q1[$];   // same for the fixed-priority instance
  int          glog0[$];    // observed grant order, rr
  int          glog1[$];    // observed grant order, fp
  logic [1:0]  last_ready [2];
  bit          noise_en;

  bit          m_busy [2];
  bit          m_gap [2];
  bit          m_ptr [2];
  bit          m_owner [2];
  bit          m_killed [2];
  int          m_left [2];
  logic [1:0]  m_op [2];
  logic [1:0]  m_mode [2];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  logic [1:0]  m_rsp_v [2];
  logic [31:0] m_rsp_d [2][2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result of a multdiv operation
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] mode,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [65:0] prod;
    logic        sgn;
    sa   = mode[0] ? {a[31], a} : {1'b0, a};
    sb   = mode[1] ? {b[31], b} : {1'b0, b};
    prod = sa * sb;
    sgn  = (mode == 2'b11);
    case (op)
      2'd0: return prod[31:0];
      2'd1: return prod[63:32];
      2'd2: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        if (sgn) return $signed(a) / $signed(b);
        return a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        if (sgn) return $signed(a) % $signed(b);
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    if (op < 2) return 33;
    if (b == 32'h0) return 2;
    return 37;
  endfunction

  // Which port the arbiter should accept this cycle
  function automatic logic [1:0] exp_grant(input int i);
    logic e0;
    logic e1;
    if (m_busy[i] || m_gap[i]) return 2'b00;
    e0 = req_valid[i][0] && !m_rsp_v[i][0] && !kill[i];
    e1 = req_valid[i][1] && !m_rsp_v[i][1];
    if (e0 && e1) return (i == 1 || !m_ptr[i]) ? 2'b01 : 2'b10;
    return {e1, e0};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_gap[i] = 0; m_ptr[i] = 0; m_owner[i] = 0; m_killed[i] = 0;
      m_left[i] = 0; m_op[i] = 0; m_mode[i] = 0; m_a[i] = 0; m_b[i] = 0;
      m_rsp_v[i] = 2'b00; m_rsp_d[i][0] = 32'h0; m_rsp_d[i][1] = 32'h0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 2'b00; req_operator[i] = '0; req_mode[i] = '0;
      req_a[i] = '0; req_b[i] = '0; kill[i] = 1'b0; rsp_ready[i] = 2'b00;
      md_ready[i] = 1'b0; md_result[i] = 32'h0;
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [1:0] op, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 2; i++) begin
      req_valid[i][p] = v; req_operator[i][p] = op; req_mode[i][p] = mode;
      req_a[i][p] = a; req_b[i][p] = b;
    end
  endtask

  task automatic set_ctl(input logic k, input logic [1:0] rr);
    for (int i = 0; i < 2; i++) begin
      kill[i] = k; rsp_ready[i] = rr;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req_valid[i][p]    = ($urandom_range(0, 3) != 0);
        req_operator[i][p] = 2'($urandom_range(0, 3));
        req_mode[i][p]     = 2'($urandom_range(0, 3));
        req_a[i][p]        = $urandom;
        req_b[i][p]        = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      end
      kill[i]      = ($urandom_range(0, 15) == 0);
      rsp_ready[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // One clock cycle: play the unit, check outputs, advance the reference.
  // Entered and left just after a falling edge.
  task automatic step();
    logic [1:0]  g [2];
    logic [1:0]  cap;
    logic [31:0] res;
    string       nm;
    int          gp;
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] && m_left[i] == 1) begin
        md_ready[i]  = 1'b1;
        md_result[i] = (i == 0) ? exp_q0[0] : exp_q1[0];
      end else begin
        md_ready[i]  = !m_busy[i] && noise_en && ($urandom_range(0, 3) == 0);
        md_result[i] = $urandom;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      nm   = (i == 0) ? "rr" : "fp";
      g[i] = exp_grant(i);
      chk({nm, ".req_ready"}, 64'(req_ready[i]), 64'(g[i]));
      last_ready[i] = req_ready[i];
      if (req_ready[i] != 2'b00) begin
        if (i == 0) glog0.push_back(int'(req_ready[i][1]));
        else        glog1.push_back(int'(req_ready[i][1]));
      end
      chk({nm, ".rsp_valid"}, 64'(rsp_valid[i]), 64'(m_rsp_v[i]));
      chk({nm, ".rsp_result0"}, 64'(rsp_result[i][0]), 64'(m_rsp_d[i][0]));
      chk({nm, ".rsp_result1"}, 64'(rsp_result[i][1]), 64'(m_rsp_d[i][1]));
      chk({nm, ".mult_en"}, 64'(md_mult_en[i]), 64'(m_busy[i] && m_op[i] < 2));
      chk({nm, ".div_en"}, 64'(md_div_en[i]), 64'(m_busy[i] && m_op[i] >= 2));
      if (m_busy[i]) begin
        chk({nm, ".md_ctrl"}, 64'({md_operator[i], md_mode[i]}), 64'({m_op[i], m_mode[i]}));
        chk({nm, ".md_ops"}, {md_a[i], md_b[i]}, {m_a[i], m_b[i]});
      end
    end
    // reference update for the coming edge
    for (int i = 0; i < 2; i++) begin
      cap = 2'b00;
      res = 32'h0;
      if (m_busy[i] && m_left[i] == 1) begin
        res = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (m_owner[i]) cap = 2'b10;
        else if (!(m_killed[i] || kill[i])) cap = 2'b01;
      end
      for (int p = 0; p < 2; p++) begin
        if (cap[p]) begin
          m_rsp_v[i][p] = 1'b1;
          m_rsp_d[i][p] = res;
        end else if (rsp_ready[i][p] || (p == 0 && kill[i])) begin
          m_rsp_v[i][p] = 1'b0;
        end
      end
      if (m_busy[i] && !m_owner[i] && kill[i]) m_killed[i] = 1;
      if (m_busy[i]) begin
        if (m_left[i] == 1) begin
          m_busy[i] = 0;
          m_gap[i]  = 1;
        end else begin
          m_left[i]--;
        end
      end else if (m_gap[i]) begin
        m_gap[i] = 0;
      end else if (g[i] != 2'b00) begin
        gp          = int'(g[i][1]);
        m_owner[i]  = g[i][1];
        m_op[i]     = req_operator[i][gp];
        m_mode[i]   = req_mode[i][gp];
        m_a[i]      = req_a[i][gp];
        m_b[i]      = req_b[i][gp];
        m_left[i]   = ref_latency(m_op[i], m_b[i]);
        m_killed[i] = 0;
        m_busy[i]   = 1;
        m_ptr[i]    = !m_ptr[i];
        if (i == 0) exp_q0.push_back(ref_result(m_op[i], m_mode[i], m_a[i], m_b[i]));
        else        exp_q1.push_back(ref_result(m_op[i], m_mode[i], m_a[i], m_b[i]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_zero_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".req_ready"}, 64'(req_ready[i]), 64'(0));
      chk({tag, ".rsp_valid"}, 64'(rsp_valid[i]), 64'(0));
      chk({tag, ".rsp_result"}, 64'(rsp_result[i]), 64'(0));
      chk({tag, ".md_en"}, 64'({md_mult_en[i], md_div_en[i]}), 64'(0));
      chk({tag, ".md_ctrl"}, 64'({md_operator[i], md_mode[i]}), 64'(0));
      chk({tag, ".md_ops"}, {md_a[i], md_b[i]}, 64'(0));
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
  endtask

  // Single isolated operation on one port, measuring accept-to-response latency
  task automatic run_single(input string tag, input int p, input logic [1:0] op,
                            input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat, input logic [31:0] exp_res);
    int k;
    set_req(p, 1'b1, op, mode, a, b);
    step();
    chk({tag, ".accept"}, 64'(last_ready[0]), 64'((p == 0) ? 2'b01 : 2'b10));
    set_req(p, 1'b0, op, mode, a, b);
    k = 1;
    while (!rsp_valid[0][p] && k < 100) begin
      step();
      k++;
    end
    chk({tag, ".latency"}, 64'(k), 64'(exp_lat));
    chk({tag, ".result"}, 64'(rsp_result[0][p]), 64'(exp_res));
    chk({tag, ".gap_en"}, 64'({md_mult_en[0], md_div_en[0]}), 64'(0));
    set_ctl(1'b0, (p == 0) ? 2'b01 : 2'b10);
    step();
    set_ctl(1'b0, 2'b00);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   k;
    int   n;
    logic seen;
    logic got;
    logic [31:0] hold_exp;

    noise_en = 0;
    set_idle();
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_zero_check("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // isolated operations with documented results and latencies
    run_single("mull", 0, 2'd0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
    run_single("div", 1, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 38, 32'h8000_0000);
    run_single("rem0", 1, 2'd3, 2'b11, 32'h0000_0005, 32'h0000_0000, 3, 32'h0000_0005);

    // both ports requesting continuously, responses consumed at once
    do_reset();
    glog0.delete();
    glog1.delete();
    set_req(0, 1'b1, 2'd0, 2'b00, 32'd3, 32'd5);
    set_req(1, 1'b1, 2'd0, 2'b00, 32'd9, 32'd11);
    set_ctl(1'b0, 2'b11);
    n = 0;
    while ((glog0.size() < 4 || glog1.size() < 4) && n < 400) begin
      step();
      n++;
    end
    chk("arb.rr_count", 64'(glog0.size() >= 4), 64'(1));
    chk("arb.fp_count", 64'(glog1.size() >= 4), 64'(1));
    for (int j = 0; j < 4 && j < glog0.size(); j++) chk("arb.rr_order", 64'(glog0[j]), 64'(j % 2));
    for (int j = 0; j < 4 && j < glog1.size(); j++) chk("arb.fp_order", 64'(glog1[j]), 64'(0));

    // kill mid-BUSY on a port-0 DIV; port 1 waits until after GAP
    do_reset();
    set_req(0, 1'b1, 2'd2, 2'b00, 32'd100, 32'd7);
    step();
    chk("kill.accept", 64'(last_ready[0]), 64'(2'b01));
    set_req(0, 1'b0, 2'd2, 2'b00, 32'd100, 32'd7);
    k = 1;
    seen = 1'b0;
    got = 1'b0;
    while (!got && k < 100) begin
      if (k == 10) set_req(1, 1'b1, 2'd0, 2'b01, 32'h1234, 32'h5678);
      set_ctl(k == 12, 2'b00);
      step();
      got = last_ready[0][1];
      seen = seen | rsp_valid[0][0];
      if (!got) k++;
    end
    chk("kill.p1_grant_cycle", 64'(k), 64'(39));
    chk("kill.fp_grant", 64'(last_ready[1]), 64'(2'b10));
    chk("kill.no_rsp0", 64'(seen), 64'(0));
    set_req(1, 1'b0, 2'd0, 2'b01, 32'h1234, 32'h5678);

    // kill together with a port-0 request in IDLE: port 1 wins
    do_reset();
    set_req(0, 1'b1, 2'd0, 2'b00, 32'd2, 32'd3);
    set_req(1, 1'b1, 2'd1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0010);
    set_ctl(1'b1, 2'b00);
    step();
    chk("kill_idle.rr", 64'(last_ready[0]), 64'(2'b10));
    chk("kill_idle.fp", 64'(last_ready[1]), 64'(2'b10));
    set_req(0, 1'b0, 2'd0, 2'b00, 32'd2, 32'd3);
    set_ctl(1'b0, 2'b00);

    // port-1 response held unconsumed while port 1 keeps requesting
    hold_exp = ref_result(2'd1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0010);
    k = 0;
    while (!rsp_valid[0][1] && k < 100) begin
      step();
      k++;
    end
    repeat (10) begin
      step();
      chk("hold.valid", 64'(rsp_valid[0][1]), 64'(1));
      chk("hold.result", 64'(rsp_result[0][1]), 64'(hold_exp));
      chk("hold.no_regrant", 64'(last_ready[0]), 64'(2'b00));
    end
    set_ctl(1'b0, 2'b10);
    step();
    set_ctl(1'b0, 2'b00);
    step();
    chk("hold.regrant", 64'(last_ready[0]), 64'(2'b10));
    set_req(1, 1'b0, 2'd1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0010);

    // asynchronous reset in the middle of BUSY
    repeat (5) step();
    set_idle();
    rst_n = 1'b0;
    #1;
    reset_zero_check("rst_mid");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 2'd0, 2'b00, 32'd11, 32'd13);
    step();
    chk("rst_mid.grant", 64'(last_ready[0]), 64'(2'b01));
    set_req(0, 1'b0, 2'd0, 2'b00, 32'd11, 32'd13);

    // random traffic against the reference
    noise_en = 1;
    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_multdiv_arb.md
# zeroriscy_multdiv_arb

Two-port request/response front end for the shared slow multiplier/divider. It arbitrates between the core pipeline (port 0) and the coprocessor port (port 1), registers the winner's operands and holds them stable to the multdiv unit until the unit signals ready. It captures the result into a per-port response register and discards results for port-0 operations killed by a pipeline flush. It sits between the ID/EX stage, the coprocessor interface and the multdiv unit.

## Interface
- FIXED_PRIO, default 0: 1 = port 0 always wins; 0 = round-robin.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-port request valid
- req_ready_o  out  2  per-port request accepted this cycle
- req_operator_i  in  2x2  per-port operator: 0 MULL, 1 MULH, 2 DIV, 3 REM
- req_signed_mode_i  in  2x2  per-port {b_signed, a_signed}
- req_op_a_i, req_op_b_i  in  2x32  per-port operands
- kill_i  in  1  flush of port-0 operation (accepted or being offered)
- rsp_valid_o  out  2  per-port result valid
- rsp_result_o  out  2x32  per-port result
- rsp_ready_i  in  2  per-port result consumed
- md_mult_en_o, md_div_en_o  out  1  enables to multdiv unit
- md_operator_o, md_signed_mode_o  out  2  held operator / signed mode
- md_op_a_o, md_op_b_o  out  32  held operands
- md_ready_i  in  1  multdiv ready
- md_result_i  in  32  multdiv result, valid only while md_ready_i=1

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE: eligible port p has req_valid_i[p]=1, rsp_valid_o[p]=0, and for p=0 kill_i=0. Grant goes to one eligible port: port 0 if FIXED_PRIO, else the port the round-robin pointer selects. The pointer is 0 at reset and flips to the other port after every grant.
- On grant: assert req_ready_o[p] combinationally, register operator/mode/operands/owner, then go to BUSY. Only one req_ready_o bit is high per cycle, and only in IDLE.
- BUSY: md_mult_en_o = (operator < 2), md_div_en_o = (operator >= 2). All md_* outputs come from registers and are constant for the whole of BUSY.
- BUSY with md_ready_i=1: capture md_result_i into the owner's response register and set rsp_valid_o[owner], unless the owner is port 0 and the op is marked killed. Then go to GAP.
- GAP: enables low for one cycle so the unit settles in its idle state. Then go to IDLE.
- kill_i:
  - kill_i=1 during BUSY with owner 0 sets the killed flag. The operation runs to completion because the unit has no abort; the result is dropped and no rsp_valid_o[0] is produced.
  - kill_i=1 clears a pending rsp_valid_o[0] at the next edge.
  - kill_i=1 has no effect on port 1.
- Response: rsp_valid_o[p] holds with a stable value until rsp_ready_i[p]=1, then clears at the next edge. Capture and consume for the same port cannot coincide, because a port is not granted while its response is pending.
- md_ready_i outside BUSY is ignored.
- Reset: state IDLE, pointer 0, killed 0. All outputs 0: req_ready_o, rsp_valid_o, rsp_result_o, md_* all 0.

## Timing
- Accept at edge T. Enables high from cycle T+1.
- Unit latency N cycles from first enabled cycle to ready cycle:
  - MULL/MULH: N=33.
  - DIV/REM: N=37.
  - DIV/REM with op_b=0: N=2.
- Timeline: md_ready_i in cycle T+N, rsp_valid_o rises in cycle T+N+1, GAP in T+N+1, next grant possible in T+N+2.
- Back-to-back throughput per op: N+2 cycles.
- Responses are registered; there is no combinational path from md_ready_i to rsp_valid_o.
- req_ready_o is combinational from req_valid_i, kill_i and state.

## Test plan
- Port 0 MULL 0x0000_0007 x 0xFFFF_FFFD, signed_mode=3: rsp_valid_o[0] 34 cycles after accept, result 0xFFFF_FFEB. Enables low during GAP.
- Port 1 DIV 0x8000_0000 / 0xFFFF_FFFF, signed: result 0x8000_0000 after 38 cycles. Then REM 5/0: result 0x0000_0005 after 3 cycles.
- Both ports request continuously with FIXED_PRIO=0: grants alternate 0,1,0,1. With FIXED_PRIO=1, port 0 always wins while its response is consumed each time.
- kill_i pulsed mid-BUSY on port-0 DIV: no rsp_valid_o[0]. Port 1 request pending during that time is granted only after GAP.
- kill_i together with req_valid_i[0] in IDLE: req_ready_o[0]=0. Same cycle, port 1 is granted if valid.
- rsp_ready_i[1] held low for 10 cycles: rsp_result_o[1] stable and port 1 not re-granted. rst_n asserted mid-BUSY: all outputs 0 immediately, clean grant after release.
